ref_fetch_sched: RTL
====================

// Module: ref_fetch_sched
// PURPOSE
//  Fetch scheduler feeding the reference-pixel SRAM stage. Walks one frame strip by strip, column by
//  column (WIN_ROWS rows x 8 px per column), issues word reads to frame memory, buffers returns in a
//  prefetch FIFO, drives ref_in one word per cycle when read_en is high, and holds the SRAM stage in
//  reset (sram_rst) until the FIFO is prefilled.
// PARAMETERS
//  WIN_ROWS    23    rows per column fetch; must match the SRAM stage address range 0..22
//  COLS        482   8-px columns per strip; must match the SRAM stage block count (0..481)
//  LINE_WORDS  482   frame-memory words per pixel row (stride)
//  STRIP_STEP  16    rows advanced between strips
//  NUM_STRIPS  68    strips per frame
//  FIFO_DEPTH  32    prefetch FIFO entries (power of 2, >= WIN_ROWS+1)
//  MAX_OUTST   8     maximum granted-but-not-returned reads
//  AW          24    frame-memory word-address width
// PORTS
//  clk         in   1    clock
//  rst         in   1    synchronous active-high reset
//  start       in   1    1-cycle pulse: begin frame at frame_base (ignored unless IDLE)
//  frame_base  in   AW   word address of frame row 0, column 0; sampled on start
//  mem_req     out  1    read request; held with mem_addr until mem_gnt
//  mem_addr    out  AW   word address of request
//  mem_gnt     in   1    request accepted this cycle
//  mem_rvalid  in   1    read data valid (in-order returns, any latency >= 1)
//  mem_rdata   in   64   8 pixels, pixel 0 in [63:56]
//  read_en     in   1    SRAM stage consumes ref_in this cycle
//  ref_in      out  64   FIFO head word to SRAM stage
//  sram_rst    out  1    reset to SRAM stage
//  busy        out  1    frame in progress
//  frame_done  out  1    1-cycle pulse after last word of last strip consumed
//  underrun    out  1    sticky: read_en seen with FIFO empty; cleared by rst or start
// BEHAVIOUR
//  Reset: FSM=IDLE, counters/FIFO/outstanding cleared; mem_req=0, mem_addr=0, ref_in=0, sram_rst=1,
//   busy=0, frame_done=0, underrun=0. Reset mid-frame discards in-flight returns (late rvalid ignored
//   until next start only while outstanding>0 before reset is NOT tracked: bench must idle memory).
//  Issue order: col c=0..COLS-1, row r=0..WIN_ROWS-1; addr = base + (strip_row + r)*LINE_WORDS + c,
//   strip_row = s*STRIP_STEP, s=0..NUM_STRIPS-1. Row-major products via incremental adders, no multiply.
//   Address arithmetic modulo 2^AW.
//  Credit: mem_req=1 only if issue pointer not exhausted and occupancy+outstanding < FIFO_DEPTH and
//   outstanding < MAX_OUTST. outstanding += gnt, -= rvalid (simultaneous: unchanged).
//  FIFO: push on mem_rvalid, pop on read_en & !empty; push+pop same cycle legal when full or empty
//   (empty: pushed word not forwarded same cycle, ref_in=0). ref_in = head when !empty else 0.
//  FSM:
//   IDLE    : sram_rst=1, busy=0. start -> PREFILL (latch base, s=0, clear underrun).
//   PREFILL : sram_rst=1, requests strip s. When occupancy >= WIN_ROWS+1 -> STREAM.
//   STREAM  : sram_rst=0; SRAM stage consumes COLS*WIN_ROWS words then idles WIN_ROWS cycles
//             (read_en low). Requests continue, crossing into next strip's addresses.
//             Consumed count reaches COLS*WIN_ROWS: s==NUM_STRIPS-1 -> DRAIN, else s++ stay STREAM.
//   DRAIN   : no new requests; wait outstanding==0 and FIFO empty; pulse frame_done, -> IDLE.
//  sram_rst deasserts exactly 1 cycle after PREFILL->STREAM, so first read_en (row0,col0) sees head.
//  Issue pointer exhausted after last strip: mem_req held 0 while consumption finishes.
//  start while busy: ignored, no effect on counters or underrun.
//  underrun: set when read_en & empty in STREAM; ref_in=0 that cycle; consumed count still advances.
// TESTING
//  1 Reset, start base=0x1000, zero-latency-1 memory, gnt always 1 -> first addrs 0x1000,0x11E2,0x13C4
//    (stride 482); sram_rst falls after 24 words buffered; no underrun over whole frame.
//  2 Strip boundary: after 11086 words consumed, next ref_in = word at base+16*482+0; frame_done
//    pulses once after 68 strips, busy falls same cycle.
//  3 Backpressure: gnt toggles 1-of-4, latency 12 -> outstanding never >8, occupancy never >32,
//    underrun=1 sticky, cleared by next start.
//  4 FIFO full + simultaneous rvalid/read_en -> occupancy unchanged, no data loss (scoreboard order).
//  5 Reset asserted mid-STREAM col 100 -> next cycle all outputs at reset values, sram_rst=1; new start
//    restarts at col 0 row 0.
//  6 start pulsed while busy -> ignored; address sequence identical to undisturbed run.

Source files
------------

// File: rtl/ref_fetch_sched.sv
// Fetch scheduler: walks a frame strip/column/row, prefetches frame-memory words into a FIFO for the SRAM stage.
// Latency: ref_in shows the FIFO head combinationally; a return is visible on ref_in the cycle after mem_rvalid.
// Backpressure: requests are credit-limited by FIFO space and outstanding reads; read_en with an empty FIFO flags underrun.
module ref_fetch_sched #(
    parameter int WIN_ROWS   = 23,
    parameter int COLS       = 482,
    parameter int LINE_WORDS = 482,
    parameter int STRIP_STEP = 16,
    parameter int NUM_STRIPS = 68,
    parameter int FIFO_DEPTH = 32,
    parameter int MAX_OUTST  = 8,
    parameter int AW         = 24
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] frame_base,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    input  logic          mem_gnt,
    input  logic          mem_rvalid,
    input  logic [63:0]   mem_rdata,
    input  logic          read_en,
    output logic [63:0]   ref_in,
    output logic          sram_rst,
    output logic          busy,
    output logic          frame_done,
    output logic          underrun
);

    localparam int STRIP_WORDS = COLS * WIN_ROWS;
    localparam int RW  = $clog2(WIN_ROWS + 1);
    localparam int CLW = $clog2(COLS + 1);
    localparam int SW  = $clog2(NUM_STRIPS + 1);
    localparam int CNW = $clog2(STRIP_WORDS + 1);
    localparam int FAW = $clog2(FIFO_DEPTH);
    localparam int OW  = $clog2(FIFO_DEPTH + 1);
    localparam int OSW = $clog2(MAX_OUTST + 1);

    localparam logic [RW-1:0]  ROW_LAST    = RW'(WIN_ROWS - 1);
    localparam logic [CLW-1:0] COL_LAST    = CLW'(COLS - 1);
    localparam logic [SW-1:0]  STRIP_LAST  = SW'(NUM_STRIPS - 1);
    localparam logic [CNW-1:0] CNT_LAST    = CNW'(STRIP_WORDS - 1);
    localparam logic [OW-1:0]  OCC_FULL    = OW'(FIFO_DEPTH);
    localparam logic [OW-1:0]  OCC_PREFILL = OW'(WIN_ROWS + 1);
    localparam logic [OW:0]    INFL_LIM    = (OW+1)'(FIFO_DEPTH);
    localparam logic [OSW-1:0] OUT_LIM     = OSW'(MAX_OUTST);
    localparam logic [AW-1:0]  ADDR_LINE   = AW'(LINE_WORDS);
    localparam logic [AW-1:0]  ADDR_STRIP  = AW'(STRIP_STEP * LINE_WORDS);

    typedef enum logic [1:0] {S_IDLE, S_PREFILL, S_STREAM, S_DRAIN} state_t;

    state_t          state, state_n;
    logic            done_evt;
    logic [SW-1:0]   strip;
    logic [CNW-1:0]  cons_cnt;
    logic [RW-1:0]   iss_row;
    logic [CLW-1:0]  iss_col;
    logic [SW-1:0]   iss_strip;
    logic            iss_done;
    logic [AW-1:0]   strip_base, col_top, cur_addr;
    logic [OSW-1:0]  outst;
    logic [63:0]     fifo_mem [FIFO_DEPTH];
    logic [FAW-1:0]  wr_ptr, rd_ptr;
    logic [OW-1:0]   occ;
    logic            sram_rst_q, frame_done_q, underrun_q;

    logic            fifo_empty, fifo_full, start_evt, issue, ret, ret_dec;
    logic            push_ok, pop, cons_evt, last_word;
    logic [OW:0]     inflight;

    assign fifo_empty = (occ == '0);
    assign fifo_full  = (occ == OCC_FULL);
    assign inflight   = (OW+1)'(occ) + (OW+1)'(outst);
    assign start_evt  = (state == S_IDLE) && start;
    assign mem_req    = ((state == S_PREFILL) || (state == S_STREAM)) && !iss_done
                        && (inflight < INFL_LIM) && (outst < OUT_LIM);
    assign issue      = mem_req && mem_gnt;
    assign ret        = mem_rvalid && (state != S_IDLE);
    assign ret_dec    = ret && (outst != '0);
    // DRAIN also flushes: after an underrun the FIFO can hold words nobody will read.
    assign pop        = (read_en || (state == S_DRAIN)) && !fifo_empty;
    assign push_ok    = ret && (!fifo_full || pop);
    assign cons_evt   = (state == S_STREAM) && read_en;
    assign last_word  = (cons_cnt == CNT_LAST);

    assign mem_addr   = cur_addr;
    assign ref_in     = fifo_empty ? '0 : fifo_mem[rd_ptr];
    assign sram_rst   = sram_rst_q;
    assign busy       = (state != S_IDLE);
    assign frame_done = frame_done_q;
    assign underrun   = underrun_q;

    always_comb begin
        state_n  = state;
        done_evt = 1'b0;
        case (state)
            S_IDLE:    if (start) state_n = S_PREFILL;
            S_PREFILL: if (occ >= OCC_PREFILL) state_n = S_STREAM;
            S_STREAM:  if (cons_evt && last_word && (strip == STRIP_LAST)) state_n = S_DRAIN;
            S_DRAIN: begin
                if ((outst == '0) && fifo_empty) begin
                    state_n  = S_IDLE;
                    done_evt = 1'b1;
                end
            end
            default:   state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            sram_rst_q   <= 1'b1;
            frame_done_q <= 1'b0;
            underrun_q   <= 1'b0;
            strip        <= '0;
            cons_cnt     <= '0;
        end else begin
            state        <= state_n;
            // released one cycle after entering STREAM, re-asserted as the frame ends
            sram_rst_q   <= !(((state == S_STREAM) || (state == S_DRAIN)) && (state_n != S_IDLE));
            frame_done_q <= done_evt;
            if (start_evt) begin
                underrun_q <= 1'b0;
                strip      <= '0;
                cons_cnt   <= '0;
            end else if (cons_evt) begin
                if (fifo_empty) underrun_q <= 1'b1;
                if (last_word) begin
                    cons_cnt <= '0;
                    if (strip != STRIP_LAST) strip <= strip + 1'b1;
                end else begin
                    cons_cnt <= cons_cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            iss_row    <= '0;
            iss_col    <= '0;
            iss_strip  <= '0;
            iss_done   <= 1'b0;
            strip_base <= '0;
            col_top    <= '0;
            cur_addr   <= '0;
        end else if (start_evt) begin
            iss_row    <= '0;
            iss_col    <= '0;
            iss_strip  <= '0;
            iss_done   <= 1'b0;
            strip_base <= frame_base;
            col_top    <= frame_base;
            cur_addr   <= frame_base;
        end else if (issue) begin
            if (iss_row != ROW_LAST) begin
                iss_row  <= iss_row + 1'b1;
                cur_addr <= cur_addr + ADDR_LINE;
            end else begin
                iss_row <= '0;
                if (iss_col != COL_LAST) begin
                    iss_col  <= iss_col + 1'b1;
                    col_top  <= col_top + 1'b1;
                    cur_addr <= col_top + 1'b1;
                end else begin
                    iss_col    <= '0;
                    iss_strip  <= iss_strip + 1'b1;
                    strip_base <= strip_base + ADDR_STRIP;
                    col_top    <= strip_base + ADDR_STRIP;
                    cur_addr   <= strip_base + ADDR_STRIP;
                    if (iss_strip == STRIP_LAST) iss_done <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            outst <= '0;
        end else begin
            case ({issue, ret_dec})
                2'b10:   outst <= outst + 1'b1;
                2'b01:   outst <= outst - 1'b1;
                default: outst <= outst;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else if (start_evt) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) fifo_mem[wr_ptr] <= mem_rdata;
    end

endmodule
